// File: rtl/dsp_bb_pkg.sv
// Shared helpers for the DSP building-block slice: integer log2 and max.
// Latency: n/a (elaboration-time functions only).
// Backpressure: n/a.
package dsp_bb_pkg;

  // Ceiling log2; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches ptr+1, ptr+2, ... modulo NREQ for the first requester.
// Latency: grant is combinational from the registered pointer; pointer moves 1 cycle after advance.
// Backpressure: pointer holds whenever i_advance is low, so a stalled grant is re-offered.
// Ports: i_clk, i_reset (sync, high), i_req[NREQ], i_advance -> o_grant (one-hot), o_grant_idx, o_any.
module rr_arbiter
  import dsp_bb_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = (clog2(NREQ) < 1) ? 1 : clog2(NREQ)
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic [NREQ-1:0] i_req,
  input  logic            i_advance,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_grant_idx,
  output logic            o_any
);

  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] ptr_d;
  logic [IDW-1:0] idx_sel;
  logic           found;
  int             cand;

  // Priority starts just after the last granted lane; first hit wins.
  always_comb begin
    found   = 1'b0;
    idx_sel = '0;
    cand    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(ptr_q) + k) % NREQ;
      if (!found && i_req[cand]) begin
        found   = 1'b1;
        idx_sel = IDW'(cand);
      end
    end
  end

  always_comb begin
    o_grant = '0;
    if (found) o_grant[idx_sel] = 1'b1;
  end

  assign o_grant_idx = idx_sel;
  assign o_any       = found;

  assign ptr_d = i_advance ? idx_sel : ptr_q;

  // Reset to NREQ-1 so lane 0 has top priority on the first arbitration.
  always_ff @(posedge i_clk) begin
    if (i_reset) ptr_q <= IDW'(NREQ - 1);
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/signed_adder.sv
// Purely combinational exact signed adder; both operands sign-extended to OWIDTH.
// Latency: 0 cycles (combinational).
// Backpressure: none; output follows inputs.
// Ports: i_a (AWIDTH signed), i_b (BWIDTH signed) -> o_sum (OWIDTH signed).
module signed_adder #(
  parameter int AWIDTH = 4,
  parameter int BWIDTH = 3,
  parameter int OWIDTH = 5
) (
  input  logic [AWIDTH-1:0] i_a,
  input  logic [BWIDTH-1:0] i_b,
  output logic [OWIDTH-1:0] o_sum
);

  logic [OWIDTH-1:0] a_ext;
  logic [OWIDTH-1:0] b_ext;

  // OWIDTH is always wider than both operands, so the replication counts are >= 1.
  assign a_ext = {{(OWIDTH-AWIDTH){i_a[AWIDTH-1]}}, i_a};
  assign b_ext = {{(OWIDTH-BWIDTH){i_b[BWIDTH-1]}}, i_b};
  assign o_sum = a_ext + b_ext;

endmodule

// File: rtl/signed_adder_arbiter.sv
// Shares one signed adder between NREQ requesters via round-robin; results tagged with requester id.
// Latency: accept at edge t, result presented after edge t+1 (consumer samples it at edge t+2); 1/cycle.
// Backpressure: i_res_ready low stalls stage 2; with stage 1 also full, all o_req_ready drop.
// Ports: i_clk, i_reset; i_req_valid/i_req_a/i_req_b/o_req_ready (per-lane request side);
//        o_res_valid/o_res_sum/o_res_id/i_res_ready (result side); o_busy (any stage occupied).
module signed_adder_arbiter
  import dsp_bb_pkg::*;
#(
  parameter  int NREQ   = 4,
  parameter  int AWIDTH = 4,
  parameter  int BWIDTH = 3,
  localparam int IDW    = (clog2(NREQ) < 1) ? 1 : clog2(NREQ),
  localparam int OUTWID = max_int(AWIDTH, BWIDTH) + 1
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [NREQ-1:0]        i_req_valid,
  input  logic [NREQ*AWIDTH-1:0] i_req_a,
  input  logic [NREQ*BWIDTH-1:0] i_req_b,
  output logic [NREQ-1:0]        o_req_ready,
  output logic                   o_res_valid,
  output logic [OUTWID-1:0]      o_res_sum,
  output logic [IDW-1:0]         o_res_id,
  input  logic                   i_res_ready,
  output logic                   o_busy
);

  // Stage 1: captured operands.
  logic              s1_valid_q, s1_valid_d;
  logic [AWIDTH-1:0] s1_a_q, s1_a_d;
  logic [BWIDTH-1:0] s1_b_q, s1_b_d;
  logic [IDW-1:0]    s1_id_q, s1_id_d;

  // Stage 2: registered result.
  logic              s2_valid_q, s2_valid_d;
  logic [OUTWID-1:0] s2_sum_q, s2_sum_d;
  logic [IDW-1:0]    s2_id_q, s2_id_d;

  logic              s1_en;
  logic              s2_en;
  logic [NREQ-1:0]   grant_oh;
  logic [IDW-1:0]    grant_idx;
  logic              any_valid;
  logic              transfer;
  logic [AWIDTH-1:0] lane_a;
  logic [BWIDTH-1:0] lane_b;
  logic [OUTWID-1:0] sum;

  assign s2_en = !s2_valid_q || i_res_ready;
  assign s1_en = !s1_valid_q || s2_en;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_req       (i_req_valid),
    .i_advance   (transfer),
    .o_grant     (grant_oh),
    .o_grant_idx (grant_idx),
    .o_any       (any_valid)
  );

  // Ready depends only on valids and pipeline state, never on operand data.
  assign o_req_ready = (s1_en && any_valid && !i_reset) ? grant_oh : '0;
  assign transfer    = |(i_req_valid & o_req_ready);

  assign lane_a = i_req_a[int'(grant_idx)*AWIDTH +: AWIDTH];
  assign lane_b = i_req_b[int'(grant_idx)*BWIDTH +: BWIDTH];

  signed_adder #(
    .AWIDTH (AWIDTH),
    .BWIDTH (BWIDTH),
    .OWIDTH (OUTWID)
  ) u_add (
    .i_a   (s1_a_q),
    .i_b   (s1_b_q),
    .o_sum (sum)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_id_d    = s1_id_q;
    s2_valid_d = s2_valid_q;
    s2_sum_d   = s2_sum_q;
    s2_id_d    = s2_id_q;
    // A cycle without a transfer loads a bubble into stage 1.
    if (s1_en) begin
      s1_valid_d = transfer;
      s1_a_d     = lane_a;
      s1_b_d     = lane_b;
      s1_id_d    = grant_idx;
    end
    if (s2_en) begin
      s2_valid_d = s1_valid_q;
      s2_sum_d   = sum;
      s2_id_d    = s1_id_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_id_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_sum_q   <= '0;
      s2_id_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_id_q    <= s1_id_d;
      s2_valid_q <= s2_valid_d;
      s2_sum_q   <= s2_sum_d;
      s2_id_q    <= s2_id_d;
    end
  end

  assign o_res_valid = s2_valid_q;
  assign o_res_sum   = s2_sum_q;
  assign o_res_id    = s2_id_q;
  assign o_busy      = s1_valid_q || s2_valid_q;

endmodule

// File: tb/tb_signed_adder_arbiter.sv
// Bench for signed_adder_arbiter: directed cases plus randomized traffic against a queue-based model.
// Latency: n/a.
// Backpressure: consumer ready is driven both steady and randomly.
module tb_signed_adder_arbiter;

  localparam int NREQ = 4;

  logic        i_clk;
  logic        i_reset;
  logic [3:0]  i_req_valid;
  logic [15:0] i_req_a;
  logic [11:0] i_req_b;
  logic [3:0]  o_req_ready;
  logic        o_res_valid;
  logic [4:0]  o_res_sum;
  logic [1:0]  o_res_id;
  logic        i_res_ready;
  logic        o_busy;

  signed_adder_arbiter dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_req_valid (i_req_valid),
    .i_req_a     (i_req_a),
    .i_req_b     (i_req_b),
    .o_req_ready (o_req_ready),
    .o_res_valid (o_res_valid),
    .o_res_sum   (o_res_sum),
    .o_res_id    (o_res_id),
    .i_res_ready (i_res_ready),
    .o_busy      (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int a_v [NREQ];
  int b_v [NREQ];

  always_comb begin
    for (int n = 0; n < NREQ; n++) begin
      i_req_a[n*4 +: 4] = a_v[n][3:0];
      i_req_b[n*3 +: 3] = b_v[n][2:0];
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Reference model: queue of pairs in acceptance order, occupancy count,
  // and the id of the last lane served.
  int   sb_sum[$];
  int   sb_id[$];
  int   inflight   = 0;
  int   last_grant = NREQ - 1;
  int   n_acc      = 0;
  int   n_drain    = 0;
  int   cyc        = 0;
  int   seen_id[$];
  int   seen_cyc[$];
  logic [3:0] acc = '0;
  bit   hold_pend = 0;
  int   hold_sum;
  int   hold_id;

  always @(negedge i_clk) begin
    int exp_lane;
    int exp_rdy;
    int n;
    int s;
    int id;
    bit drained;
    bit accepted;
    if (i_reset) begin
      check_eq("rst_ready", int'(o_req_ready), 0);
      sb_sum.delete();
      sb_id.delete();
      inflight   = 0;
      last_grant = NREQ - 1;
      hold_pend  = 0;
      acc        = '0;
    end else begin
      exp_lane = -1;
      for (int k = 1; k <= NREQ; k++) begin
        n = (last_grant + k) % NREQ;
        if (exp_lane < 0 && i_req_valid[n]) exp_lane = n;
      end
      exp_rdy = (exp_lane >= 0 && (inflight < 2 || i_res_ready)) ? (1 << exp_lane) : 0;
      check_eq("ready", int'(o_req_ready), exp_rdy);
      check_eq("busy", int'(o_busy), int'(inflight > 0));
      if (inflight == 0) check_eq("idle_valid", int'(o_res_valid), 0);
      if (inflight == 2) check_eq("full_valid", int'(o_res_valid), 1);
      if (hold_pend) begin
        check_eq("hold_valid", int'(o_res_valid), 1);
        check_eq("hold_sum", int'($signed(o_res_sum)), hold_sum);
        check_eq("hold_id", int'(o_res_id), hold_id);
      end
      hold_pend = o_res_valid && !i_res_ready;
      hold_sum  = int'($signed(o_res_sum));
      hold_id   = int'(o_res_id);

      drained = 0;
      if (o_res_valid && i_res_ready) begin
        if (sb_sum.size() == 0) begin
          check_eq("res_unexpected", int'(o_res_valid), 0);
        end else begin
          s  = sb_sum.pop_front();
          id = sb_id.pop_front();
          check_eq("res_sum", int'($signed(o_res_sum)), s);
          check_eq("res_id", int'(o_res_id), id);
          drained = 1;
        end
        seen_id.push_back(int'(o_res_id));
        seen_cyc.push_back(cyc);
        n_drain++;
      end

      accepted = 0;
      if (exp_rdy != 0 && (i_req_valid & o_req_ready) != 0) begin
        sb_sum.push_back(a_v[exp_lane] + b_v[exp_lane]);
        sb_id.push_back(exp_lane);
        last_grant = exp_lane;
        accepted   = 1;
        n_acc++;
      end
      acc = i_req_valid & o_req_ready;
      inflight = inflight + int'(accepted) - int'(drained);
    end
    cyc++;
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic int rand_a();
    return int'($urandom_range(15)) - 8;
  endfunction

  function automatic int rand_b();
    return int'($urandom_range(7)) - 4;
  endfunction

  // Lanes hold data while pending; may legally withdraw; refresh after acceptance.
  task automatic drive_lanes(input int p_valid, input int p_drop);
    for (int n = 0; n < NREQ; n++) begin
      if (i_req_valid[n] && !acc[n]) begin
        if (int'($urandom_range(99)) < p_drop) i_req_valid[n] = 1'b0;
      end else begin
        i_req_valid[n] = (int'($urandom_range(99)) < p_valid);
        a_v[n] = rand_a();
        b_v[n] = rand_b();
      end
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (o_busy && t < 20) begin
      tick();
      t++;
    end
    if (o_busy) check_eq("idle_timeout", int'(o_busy), 0);
  endtask

  task automatic single_op(input int lane, input int a, input int b, input int exp_sum);
    int t;
    i_req_valid = '0;
    i_res_ready = 1'b1;
    wait_idle();
    a_v[lane] = a;
    b_v[lane] = b;
    i_req_valid[lane] = 1'b1;
    @(negedge i_clk);
    t = 0;
    while (!o_req_ready[lane] && t < 10) begin
      @(negedge i_clk);
      t++;
    end
    if (!o_req_ready[lane]) check_eq("grant_timeout", int'(o_req_ready[lane]), 1);
    tick();
    i_req_valid[lane] = 1'b0;
    @(negedge i_clk);
    check_eq("lat_s1", int'(o_res_valid), 0);
    @(negedge i_clk);
    check_eq("lat_s2", int'(o_res_valid), 1);
    check_eq("op_sum", int'($signed(o_res_sum)), exp_sum);
    check_eq("op_id", int'(o_res_id), lane);
  endtask

  int ext_a [4] = '{7, -8, -8, 7};
  int ext_b [4] = '{3, -4, 3, -4};
  int ext_s [4] = '{10, -12, -5, 3};

  initial begin
    int base;
    int t;
    i_reset     = 1'b1;
    i_req_valid = 4'hF;
    i_res_ready = 1'b1;
    for (int n = 0; n < NREQ; n++) begin
      a_v[n] = rand_a();
      b_v[n] = rand_b();
    end

    // Reset with all lanes requesting.
    tick();
    tick();
    @(negedge i_clk);
    check_eq("rst_res_valid", int'(o_res_valid), 0);
    check_eq("rst_res_sum", int'(o_res_sum), 0);
    check_eq("rst_res_id", int'(o_res_id), 0);
    check_eq("rst_busy", int'(o_busy), 0);
    tick();
    i_reset = 1'b0;
    @(negedge i_clk);
    check_eq("first_grant", int'(o_req_ready), 1);

    // Fairness: all lanes keep requesting, consumer always ready.
    seen_id.delete();
    seen_cyc.delete();
    t = 0;
    while (seen_id.size() < 8 && t < 20) begin
      tick();
      drive_lanes(100, 0);
      t++;
    end
    if (seen_id.size() < 8) begin
      check_eq("fair_timeout", seen_id.size(), 8);
    end else begin
      for (int i = 0; i < 8; i++) check_eq("fair_id", seen_id[i], i % 4);
      check_eq("fair_rate", seen_cyc[7] - seen_cyc[0], 7);
    end

    // Single lane and arithmetic extremes.
    single_op(2, -8, -4, -12);
    for (int i = 0; i < 4; i++) single_op(i, ext_a[i], ext_b[i], ext_s[i]);

    // Backpressure under full load from an empty pipeline.
    tick();
    i_req_valid = '0;
    wait_idle();
    i_res_ready = 1'b0;
    base = n_acc;
    for (int i = 0; i < 5; i++) begin
      tick();
      drive_lanes(100, 0);
    end
    @(negedge i_clk);
    check_eq("bp_accepts", n_acc - base, 2);
    check_eq("bp_ready", int'(o_req_ready), 0);

    // Randomized traffic with random consumer stalls.
    for (int i = 0; i < 1500; i++) begin
      tick();
      drive_lanes(60, 10);
      i_res_ready = (int'($urandom_range(99)) < 70);
    end

    // Reset during a stall with the pipeline full.
    tick();
    i_res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      drive_lanes(100, 0);
    end
    tick();
    i_reset     = 1'b1;
    i_req_valid = '0;
    tick();
    i_reset = 1'b0;
    @(negedge i_clk);
    check_eq("mid_rst_valid", int'(o_res_valid), 0);
    check_eq("mid_rst_busy", int'(o_busy), 0);
    base = n_drain;
    tick();
    i_res_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check_eq("no_stale", n_drain - base, 0);

    // Short random burst after reset, then drain everything.
    for (int i = 0; i < 200; i++) begin
      tick();
      drive_lanes(70, 5);
      i_res_ready = (int'($urandom_range(99)) < 80);
    end
    tick();
    i_req_valid = '0;
    i_res_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    @(negedge i_clk);
    check_eq("sb_empty", sb_sum.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
